// File: rtl/axis_bram_adapter_pkg.sv
// Shared widths, register map, engine state encoding and line slot helper
// for the AXI-Stream <-> wide BRAM line adapter.
package axis_bram_adapter_pkg;

  localparam int DATA_W  = 32;
  localparam int LINE_W  = 1152;
  localparam int WORDS   = LINE_W / DATA_W;
  localparam int ADDR_W  = 12;
  localparam int AXIL_AW = 5;
  localparam int IDX_W   = 6;
  localparam int LINE_IW = 11;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [AXIL_AW-1:0] REG_CTRL   = 5'h00;
  localparam logic [AXIL_AW-1:0] REG_START  = 5'h04;
  localparam logic [AXIL_AW-1:0] REG_END    = 5'h08;
  localparam logic [AXIL_AW-1:0] REG_STATUS = 5'h0C;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WR_FILL   = 3'd1;
  localparam state_t ST_WR_COMMIT = 3'd2;
  localparam state_t ST_RD_ISSUE  = 3'd3;
  localparam state_t ST_RD_WAIT   = 3'd4;
  localparam state_t ST_RD_SEND   = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  // LSB position of stream word slot idx inside a BRAM line (slot 0 at the LSB)
  function automatic logic [LINE_IW-1:0] slot_lsb(input logic [IDX_W-1:0] idx);
    return LINE_IW'(idx) * LINE_IW'(DATA_W);
  endfunction

endpackage

// File: rtl/axis_bram_adapter_axil_regs.sv
// AXI4-Lite register bank: CTRL (RW, RELOAD), START, END and optional STATUS.
// Optional STATUS readback is built when AXIS_BRAM_ADAPTER_STATUS_EN is defined.
// RELOAD edges are reported as single-cycle pulses one cycle after the write.
module axis_bram_adapter_axil_regs
  import axis_bram_adapter_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [AXIL_AW-1:0] awaddr_i,
  input  logic [2:0]         awprot_i,
  input  logic               awvalid_i,
  output logic               awready_o,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [3:0]         wstrb_i,
  input  logic               wvalid_i,
  output logic               wready_o,
  output logic [1:0]         bresp_o,
  output logic               bvalid_o,
  input  logic               bready_i,
  input  logic [AXIL_AW-1:0] araddr_i,
  input  logic [2:0]         arprot_i,
  input  logic               arvalid_i,
  output logic               arready_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic [1:0]         rresp_o,
  output logic               rvalid_o,
  input  logic               rready_i,
`ifdef AXIS_BRAM_ADAPTER_STATUS_EN
  input  logic [DATA_W-1:0]  status_i,
`endif
  output logic               rw_o,
  output logic [ADDR_W-1:0]  start_o,
  output logic [ADDR_W-1:0]  end_o,
  output logic               reload_rise_o,
  output logic               reload_fall_o
);

  logic [1:0]        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              reload_prev_q;
  logic              aw_rdy_q, bvalid_q, ar_rdy_q, rvalid_q;
  logic [DATA_W-1:0] rdata_q, rd_word;
  logic              wr_fire, rd_fire;
  logic              unused_ok;

  assign wr_fire = aw_rdy_q & awvalid_i & wvalid_i;
  assign rd_fire = ar_rdy_q & arvalid_i;

  // Byte-lane merge of an accepted write into the configuration registers
  always_comb begin
    ctrl_d  = ctrl_q;
    start_d = start_q;
    end_d   = end_q;
    if (wr_fire) begin
      case ({awaddr_i[AXIL_AW-1:2], 2'b00})
        REG_CTRL: if (wstrb_i[0]) ctrl_d = wdata_i[1:0];
        REG_START: begin
          if (wstrb_i[0]) start_d[7:0]  = wdata_i[7:0];
          if (wstrb_i[1]) start_d[11:8] = wdata_i[11:8];
        end
        REG_END: begin
          if (wstrb_i[0]) end_d[7:0]  = wdata_i[7:0];
          if (wstrb_i[1]) end_d[11:8] = wdata_i[11:8];
        end
        default: ;
      endcase
    end
  end

  // Read data selection; unmapped offsets return zero
  always_comb begin
    rd_word = '0;
    case ({araddr_i[AXIL_AW-1:2], 2'b00})
      REG_CTRL:   rd_word = {30'b0, ctrl_q};
      REG_START:  rd_word = {20'b0, start_q};
      REG_END:    rd_word = {20'b0, end_q};
`ifdef AXIS_BRAM_ADAPTER_STATUS_EN
      REG_STATUS: rd_word = status_i;
`endif
      default:    rd_word = '0;
    endcase
  end

  // Register state plus write/read channel handshakes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q        <= '0;
      start_q       <= '0;
      end_q         <= '0;
      reload_prev_q <= 1'b0;
      aw_rdy_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      ar_rdy_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      start_q       <= start_d;
      end_q         <= end_d;
      reload_prev_q <= ctrl_q[1];
      aw_rdy_q      <= awvalid_i & wvalid_i & ~aw_rdy_q & ~bvalid_q;
      if (wr_fire)       bvalid_q <= 1'b1;
      else if (bready_i) bvalid_q <= 1'b0;
      ar_rdy_q      <= arvalid_i & ~ar_rdy_q & ~rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign awready_o     = aw_rdy_q;
  assign wready_o      = aw_rdy_q;
  assign bvalid_o      = bvalid_q;
  assign bresp_o       = 2'b00;
  assign arready_o     = ar_rdy_q;
  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign rresp_o       = 2'b00;
  assign rw_o          = ctrl_q[0];
  assign start_o       = start_q;
  assign end_o         = end_q;
  assign reload_rise_o = ctrl_q[1] & ~reload_prev_q;
  assign reload_fall_o = ~ctrl_q[1] & reload_prev_q;

  assign unused_ok = ^{awaddr_i[1:0], araddr_i[1:0], awprot_i, arprot_i,
                       wdata_i[DATA_W-1:12], wstrb_i[3:2]};

endmodule

// File: rtl/axis_bram_adapter.sv
// AXI-Stream <-> 1152-bit BRAM line adapter. Write mode packs 36 beats per
// line (first beat at the LSB); read mode unpacks each line into 36 beats.
// Optional macro AXIS_BRAM_ADAPTER_STATUS_EN adds the STATUS register at 0x0C.
module axis_bram_adapter
  import axis_bram_adapter_pkg::*;
(
  input  logic               aclk,
  input  logic               areset,
  output logic               BRAM_CLK,
  output logic               BRAM_EN,
  output logic               BRAM_WEN,
  output logic [ADDR_W-1:0]  BRAM_ADDR,
  output logic [LINE_W-1:0]  BRAM_IN,
  input  logic [LINE_W-1:0]  BRAM_OUT,
  input  logic [DATA_W-1:0]  s00_axis_tdata,
  input  logic [3:0]         s00_axis_tstrb,
  input  logic               s00_axis_tlast,
  input  logic               s00_axis_tvalid,
  output logic               s00_axis_tready,
  output logic [DATA_W-1:0]  m00_axis_tdata,
  output logic [3:0]         m00_axis_tstrb,
  output logic               m00_axis_tlast,
  output logic               m00_axis_tvalid,
  input  logic               m00_axis_tready,
  input  logic [AXIL_AW-1:0] s02_axi_awaddr,
  input  logic [2:0]         s02_axi_awprot,
  input  logic               s02_axi_awvalid,
  output logic               s02_axi_awready,
  input  logic [DATA_W-1:0]  s02_axi_wdata,
  input  logic [3:0]         s02_axi_wstrb,
  input  logic               s02_axi_wvalid,
  output logic               s02_axi_wready,
  output logic [1:0]         s02_axi_bresp,
  output logic               s02_axi_bvalid,
  input  logic               s02_axi_bready,
  input  logic [AXIL_AW-1:0] s02_axi_araddr,
  input  logic [2:0]         s02_axi_arprot,
  input  logic               s02_axi_arvalid,
  output logic               s02_axi_arready,
  output logic [DATA_W-1:0]  s02_axi_rdata,
  output logic [1:0]         s02_axi_rresp,
  output logic               s02_axi_rvalid,
  input  logic               s02_axi_rready
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d, end_q, end_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              flush_q, flush_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] bram_in_q, bram_in_d;
  logic              cfg_rw, reload_rise, reload_fall;
  logic [ADDR_W-1:0] cfg_start, cfg_end;
  logic              unused_ok;

`ifdef AXIS_BRAM_ADAPTER_STATUS_EN
  logic [DATA_W-1:0] status;
  logic              busy;
  assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign status = {4'b0, cur_q, 2'b0, idx_q, 6'b0, state_q == ST_DONE, busy};
`endif

  axis_bram_adapter_axil_regs u_regs (
    .clk_i         (aclk),
    .rst_i         (areset),
    .awaddr_i      (s02_axi_awaddr),
    .awprot_i      (s02_axi_awprot),
    .awvalid_i     (s02_axi_awvalid),
    .awready_o     (s02_axi_awready),
    .wdata_i       (s02_axi_wdata),
    .wstrb_i       (s02_axi_wstrb),
    .wvalid_i      (s02_axi_wvalid),
    .wready_o      (s02_axi_wready),
    .bresp_o       (s02_axi_bresp),
    .bvalid_o      (s02_axi_bvalid),
    .bready_i      (s02_axi_bready),
    .araddr_i      (s02_axi_araddr),
    .arprot_i      (s02_axi_arprot),
    .arvalid_i     (s02_axi_arvalid),
    .arready_o     (s02_axi_arready),
    .rdata_o       (s02_axi_rdata),
    .rresp_o       (s02_axi_rresp),
    .rvalid_o      (s02_axi_rvalid),
    .rready_i      (s02_axi_rready),
`ifdef AXIS_BRAM_ADAPTER_STATUS_EN
    .status_i      (status),
`endif
    .rw_o          (cfg_rw),
    .start_o       (cfg_start),
    .end_o         (cfg_end),
    .reload_rise_o (reload_rise),
    .reload_fall_o (reload_fall)
  );

  // Transfer engine: RELOAD edges override the current state
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    end_d     = end_q;
    idx_d     = idx_q;
    flush_d   = flush_q;
    line_d    = line_q;
    bram_in_d = bram_in_q;
    if (reload_rise) begin
      state_d = ST_IDLE;
    end else if (reload_fall) begin
      cur_d   = cfg_start;
      end_d   = cfg_end;
      idx_d   = '0;
      flush_d = 1'b0;
      if (cfg_start > cfg_end) state_d = ST_DONE;
      else if (cfg_rw)         state_d = ST_WR_FILL;
      else                     state_d = ST_RD_ISSUE;
    end else begin
      case (state_q)
        ST_WR_FILL: begin
          if (s00_axis_tvalid) begin
            // Clearing on the first beat leaves unused slots zero after a tlast flush
            if (idx_q == '0) line_d = '0;
            line_d[slot_lsb(idx_q) +: DATA_W] = s00_axis_tdata;
            if ((idx_q == LAST_IDX) || s00_axis_tlast) begin
              bram_in_d = line_d;
              flush_d   = s00_axis_tlast;
              state_d   = ST_WR_COMMIT;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        ST_WR_COMMIT: begin
          if ((cur_q == end_q) || flush_q) begin
            state_d = ST_DONE;
          end else begin
            cur_d   = cur_q + 1'b1;
            idx_d   = '0;
            state_d = ST_WR_FILL;
          end
        end
        ST_RD_ISSUE: state_d = ST_RD_WAIT;
        ST_RD_WAIT: begin
          line_d  = BRAM_OUT;
          idx_d   = '0;
          state_d = ST_RD_SEND;
        end
        ST_RD_SEND: begin
          if (m00_axis_tready) begin
            if (idx_q == LAST_IDX) begin
              if (cur_q == end_q) begin
                state_d = ST_DONE;
              end else begin
                cur_d   = cur_q + 1'b1;
                state_d = ST_RD_ISSUE;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers; reset drops any partial line
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      end_q     <= '0;
      idx_q     <= '0;
      flush_q   <= 1'b0;
      bram_in_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      end_q     <= end_d;
      idx_q     <= idx_d;
      flush_q   <= flush_d;
      bram_in_q <= bram_in_d;
    end
  end

  // Line assembly / unpack buffer, fully rewritten before each use
  always_ff @(posedge aclk) begin
    line_q <= line_d;
  end

  assign BRAM_CLK        = aclk;
  assign BRAM_EN         = (state_q == ST_WR_COMMIT) || (state_q == ST_RD_ISSUE);
  assign BRAM_WEN        = (state_q == ST_WR_COMMIT);
  assign BRAM_ADDR       = cur_q;
  assign BRAM_IN         = bram_in_q;
  assign s00_axis_tready = (state_q == ST_WR_FILL);
  assign m00_axis_tvalid = (state_q == ST_RD_SEND);
  assign m00_axis_tdata  = (state_q == ST_RD_SEND) ? line_q[slot_lsb(idx_q) +: DATA_W] : '0;
  assign m00_axis_tstrb  = (state_q == ST_RD_SEND) ? 4'hF : 4'h0;
  assign m00_axis_tlast  = (state_q == ST_RD_SEND) && (idx_q == LAST_IDX) && (cur_q == end_q);

  assign unused_ok = ^s00_axis_tstrb;

endmodule

// File: tb/tb_axis_bram_adapter.sv
// Bench for axis_bram_adapter: register table, line write/flush, readback
// scoreboard with backpressure, and abort corner cases.
module tb_axis_bram_adapter;
  import axis_bram_adapter_pkg::*;

  logic               aclk = 1'b0;
  logic               areset;
  logic               BRAM_CLK, BRAM_EN, BRAM_WEN;
  logic [ADDR_W-1:0]  BRAM_ADDR;
  logic [LINE_W-1:0]  BRAM_IN, BRAM_OUT;
  logic [31:0]        s_tdata, m_tdata;
  logic [3:0]         s_tstrb, m_tstrb;
  logic               s_tlast, s_tvalid, s_tready, m_tlast, m_tvalid, m_tready;
  logic [4:0]         awaddr, araddr;
  logic [2:0]         awprot, arprot;
  logic [31:0]        wdata, rdata;
  logic [3:0]         wstrb;
  logic               awvalid, awready, wvalid, wready, bvalid, bready;
  logic               arvalid, arready, rvalid, rready;
  logic [1:0]         bresp, rresp;

  always #5 aclk = ~aclk;

  axis_bram_adapter dut (
    .aclk(aclk), .areset(areset), .BRAM_CLK(BRAM_CLK), .BRAM_EN(BRAM_EN),
    .BRAM_WEN(BRAM_WEN), .BRAM_ADDR(BRAM_ADDR), .BRAM_IN(BRAM_IN), .BRAM_OUT(BRAM_OUT),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready),
    .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb), .m00_axis_tlast(m_tlast),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready),
    .s02_axi_awaddr(awaddr), .s02_axi_awprot(awprot), .s02_axi_awvalid(awvalid),
    .s02_axi_awready(awready), .s02_axi_wdata(wdata), .s02_axi_wstrb(wstrb),
    .s02_axi_wvalid(wvalid), .s02_axi_wready(wready), .s02_axi_bresp(bresp),
    .s02_axi_bvalid(bvalid), .s02_axi_bready(bready), .s02_axi_araddr(araddr),
    .s02_axi_arprot(arprot), .s02_axi_arvalid(arvalid), .s02_axi_arready(arready),
    .s02_axi_rdata(rdata), .s02_axi_rresp(rresp), .s02_axi_rvalid(rvalid),
    .s02_axi_rready(rready)
  );

  // Port A of a 4096 x 1152 BRAM with one-cycle read latency; port B unused
  logic [LINE_W-1:0] mem [0:4095];
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [LINE_W-1:0] wr_data_q [$];
  initial begin
    BRAM_OUT = '0;
    for (int k = 0; k < 4096; k++) mem[k] = '0;
  end
  always @(posedge aclk) begin
    if (BRAM_EN) begin
      if (BRAM_WEN) begin
        mem[BRAM_ADDR] <= BRAM_IN;
        wr_addr_q.push_back(BRAM_ADDR);
        wr_data_q.push_back(BRAM_IN);
      end else begin
        BRAM_OUT <= mem[BRAM_ADDR];
      end
    end
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int k = 0; k < WORDS; k++)
      if (bad < 0 && act[slot_lsb(6'(k)) +: 32] !== exp[slot_lsb(6'(k)) +: 32]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: slot %0d got %h expected %h", name, bad,
               act[slot_lsb(6'(bad)) +: 32], exp[slot_lsb(6'(bad)) +: 32]);
    end
  endtask

  task automatic axil_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
    int n;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 50) begin @(negedge aclk); n++; end
    check("axil_aw_w_ready", {awready, wready}, 2'b11);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    check("axil_bvalid", bvalid, 1);
    resp = bresp;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axil_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    check("axil_arready", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1; n = 0;
    while (!rvalid && n < 50) begin @(negedge aclk); n++; end
    check("axil_rvalid", rvalid, 1);
    d = rdata; resp = rresp;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic start_xfer(input logic [11:0] st, input logic [11:0] en, input logic rw);
    logic [1:0] r;
    axil_write(REG_START, {20'b0, st}, 4'hF, r);
    axil_write(REG_END, {20'b0, en}, 4'hF, r);
    axil_write(REG_CTRL, {30'b0, 1'b1, rw}, 4'hF, r);
    axil_write(REG_CTRL, {30'b0, 1'b0, rw}, 4'hF, r);
    @(negedge aclk);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    while (!s_tready && n < 200) begin @(negedge aclk); n++; end
    check("beat_accept", s_tready, 1);
    if (s_tready) @(negedge aclk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t          vecs [10];
  logic [31:0]       rd, d, held;
  logic [1:0]        resp;
  logic [LINE_W-1:0] line1, line2, line3;
  int                beats, cyc, nwr;
  logic              stalled, en_seen;

  initial begin
    vecs[0] = '{1'b1, 5'h08, 32'h0000_0008, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 5'h08, 32'h0,         4'h0, 32'h0000_0008};
    vecs[2] = '{1'b1, 5'h04, 32'hFFFF_F123, 4'hF, 32'h0};
    vecs[3] = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h0000_0123};
    vecs[4] = '{1'b1, 5'h08, 32'h0000_0A00, 4'h2, 32'h0};
    vecs[5] = '{1'b0, 5'h08, 32'h0,         4'h0, 32'h0000_0A08};
    vecs[6] = '{1'b1, 5'h04, 32'h0000_0000, 4'h1, 32'h0};
    vecs[7] = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h0000_0100};
    vecs[8] = '{1'b0, 5'h10, 32'h0,         4'h0, 32'h0};
    vecs[9] = '{1'b0, 5'h00, 32'h0,         4'h0, 32'h0};

    areset = 1'b1;
    s_tdata = '0; s_tstrb = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", {m_tvalid, m_tlast, m_tstrb}, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_bram_ctl", {BRAM_EN, BRAM_WEN, BRAM_ADDR}, 0);
    check("rst_bram_in_lo", BRAM_IN[63:0], 0);
    check("rst_axil", {awready, wready, bvalid, arready, rvalid, rdata}, 0);
    areset = 1'b0;
    @(negedge aclk);

    // Register access table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        axil_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check("reg_bresp", resp, 0);
      end else begin
        axil_read(vecs[i].addr, rd, resp);
        check($sformatf("reg_rd_%0h", vecs[i].addr), rd, vecs[i].exp);
        check("reg_rresp", resp, 0);
      end
    end

    // Line 1: full 36-beat line into address 0
    start_xfer(12'd0, 12'd8, 1'b1);
    line1 = '0;
    for (int i = 0; i < WORDS; i++) begin
      d = (i == 0) ? 32'hBBBB_BBBB : (i == WORDS - 1) ? 32'hEEEE_EEEE :
          (i % 2 == 1) ? 32'hDDDD_DDDD : 32'hFFFF_FFFF;
      line1[slot_lsb(6'(i)) +: 32] = d;
      sb.push_back(d);
      send_beat(d, 1'b0);
    end
    check("l1_commit_bubble", {s_tready, BRAM_EN, BRAM_WEN}, 3'b011);
    check("l1_commit_addr", BRAM_ADDR, 0);
    @(negedge aclk);
    check("l1_refill_ready", s_tready, 1);
    check("l1_wr_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() >= 1) begin
      check("l1_wr_addr", wr_addr_q[0], 0);
      check("l1_bram_in_lsw", wr_data_q[0][31:0], 32'hBBBB_BBBB);
      check("l1_bram_in_msw", wr_data_q[0][1151:1120], 32'hEEEE_EEEE);
      check_line("l1_line", wr_data_q[0], line1);
    end

    // Line 2: tlast on the final beat flushes and ends before END
    line2 = '0;
    for (int i = 0; i < WORDS; i++) begin
      d = 32'hA000_0000 + i;
      line2[slot_lsb(6'(i)) +: 32] = d;
      sb.push_back(d);
      send_beat(d, i == WORDS - 1);
    end
    check("l2_commit", {BRAM_EN, BRAM_WEN, BRAM_ADDR}, {2'b11, 12'd1});
    repeat (4) @(negedge aclk);
    check("l2_done_tready", s_tready, 0);
    check("l2_wr_count", wr_addr_q.size(), 2);
    if (wr_addr_q.size() >= 2) begin
      check("l2_wr_addr", wr_addr_q[1], 1);
      check_line("l2_line", wr_data_q[1], line2);
    end

    // Readback of lines 0..1 with a 5-cycle stall mid second line
    start_xfer(12'd0, 12'd1, 1'b0);
    m_tready = 1'b1;
    beats = 0; cyc = 0; stalled = 1'b0;
    while (beats < 2 * WORDS && cyc < 2000) begin
      @(negedge aclk); cyc++;
      if (beats == 50 && m_tvalid && !stalled) begin
        stalled = 1'b1;
        m_tready = 1'b0;
        held = m_tdata;
        for (int k = 0; k < 5; k++) begin
          @(negedge aclk);
          check("stall_hold", {m_tvalid, m_tdata}, {1'b1, held});
        end
        m_tready = 1'b1;
      end
      if (m_tvalid && m_tready) begin
        d = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_0000;
        check($sformatf("rd_beat%0d", beats), m_tdata, d);
        check($sformatf("rd_last%0d", beats), {m_tlast, m_tstrb}, {beats == 2 * WORDS - 1, 4'hF});
        beats++;
      end
    end
    check("rd_beat_count", beats, 2 * WORDS);
    repeat (3) @(negedge aclk);
    check("rd_done_idle", {m_tvalid, m_tlast}, 0);
    m_tready = 1'b0;

    // Short line: three beats with tlast, unused slots must read as zero
    start_xfer(12'd2, 12'd5, 1'b1);
    line3 = '0;
    for (int i = 0; i < 3; i++) begin
      d = 32'h1111_1111 * (i + 1);
      line3[slot_lsb(6'(i)) +: 32] = d;
      send_beat(d, i == 2);
    end
    repeat (3) @(negedge aclk);
    check("short_done_tready", s_tready, 0);
    check("short_wr_count", wr_addr_q.size(), 3);
    if (wr_addr_q.size() >= 3) begin
      check("short_wr_addr", wr_addr_q[2], 2);
      check_line("short_line", wr_data_q[2], line3);
    end

    // START > END: straight to DONE with no BRAM access
    start_xfer(12'd7, 12'd3, 1'b1);
    en_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      en_seen = en_seen | BRAM_EN | s_tready;
    end
    check("empty_window_no_access", en_seen, 0);
    check("empty_window_wr_count", wr_addr_q.size(), 3);

    // Abort by RELOAD rising edge after 10 beats
    start_xfer(12'd4, 12'd5, 1'b1);
    for (int i = 0; i < 10; i++) send_beat(32'hC000_0000 + i, 1'b0);
    axil_write(REG_CTRL, 32'h3, 4'hF, resp);
    en_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge aclk);
      en_seen = en_seen | BRAM_EN | s_tready;
    end
    check("abort_reload_quiet", en_seen, 0);
    check("abort_reload_wr_count", wr_addr_q.size(), 3);

    // Abort by reset after 10 beats
    axil_write(REG_CTRL, 32'h1, 4'hF, resp);
    @(negedge aclk);
    for (int i = 0; i < 10; i++) send_beat(32'hD000_0000 + i, 1'b0);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    en_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge aclk);
      en_seen = en_seen | BRAM_EN | s_tready;
    end
    check("abort_rst_quiet", en_seen, 0);
    check("abort_rst_wr_count", wr_addr_q.size(), 3);
    axil_read(REG_END, rd, resp);
    check("abort_rst_end_reg", rd, 0);
    axil_read(REG_CTRL, rd, resp);
    check("abort_rst_ctrl_reg", rd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
